// File: rtl/bkm_data_step_scoreboard_pkg.sv
// bkm_data_step_scoreboard_pkg: scoreboard status encoding shared by RTL and bench
package bkm_data_step_scoreboard_pkg;
  typedef enum logic [1:0] {
    SB_IDLE      = 2'd0,
    SB_RUN       = 2'd1,
    SB_PASS_HOLD = 2'd2,
    SB_FAIL      = 2'd3
  } sb_state_t;
endpackage

// File: rtl/bkm_sat_counter.sv
// bkm_sat_counter: synchronous-clear counter that sticks at all-ones
module bkm_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    count <= clr ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/bkm_data_step_scoreboard.sv
// bkm_data_step_scoreboard: run statistics and pass/fail status behind the bkm_data_step checker
module bkm_data_step_scoreboard
  import bkm_data_step_scoreboard_pkg::*;
#(
  parameter int W           = 64,
  parameter int LOG2N       = 6,
  parameter int CNT_W       = 32,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             clear,
  input  logic [LOG2N-1:0] tb_n,
  input  logic [W-1:0]     delta_X,
  input  logic [W-1:0]     delta_Y,
  input  logic             err_X,
  input  logic             err_Y,
  input  logic             war_X,
  input  logic             war_Y,
  output logic [CNT_W-1:0] cnt_samples,
  output logic [CNT_W-1:0] cnt_err_X,
  output logic [CNT_W-1:0] cnt_err_Y,
  output logic [CNT_W-1:0] cnt_war_X,
  output logic [CNT_W-1:0] cnt_war_Y,
  output logic [W-1:0]     max_dX,
  output logic [W-1:0]     max_dY,
  output logic             first_err_vld,
  output logic [LOG2N-1:0] first_err_n,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       state
);
  logic             clr, en_d, judge, err, frozen;
  logic [W-1:0]     dx_d, dy_d, abs_x, abs_y;
  logic [LOG2N-1:0] n_d;
  sb_state_t        st, st_nx;
  assign clr    = srst | clear;
  assign frozen = (st == SB_FAIL) && STOP_ON_ERR;
  assign judge  = en_d && !frozen;
  assign err    = err_X | err_Y;
  assign abs_x  = dx_d[W-1] ? -dx_d : dx_d;
  assign abs_y  = dy_d[W-1] ? -dy_d : dy_d;
  assign state  = st;
  always_ff @(posedge clk) begin
    if (clr) begin
      en_d <= 1'b0;
      dx_d <= '0;
      dy_d <= '0;
      n_d  <= '0;
    end else begin
      en_d <= enable;
      if (enable) begin
        dx_d <= delta_X;
        dy_d <= delta_Y;
        n_d  <= tb_n;
      end
    end
  end
  bkm_sat_counter #(.CNT_W(CNT_W)) u_samples (.clk(clk), .clr(clr), .inc(judge),         .count(cnt_samples));
  bkm_sat_counter #(.CNT_W(CNT_W)) u_err_x   (.clk(clk), .clr(clr), .inc(judge & err_X), .count(cnt_err_X));
  bkm_sat_counter #(.CNT_W(CNT_W)) u_err_y   (.clk(clk), .clr(clr), .inc(judge & err_Y), .count(cnt_err_Y));
  bkm_sat_counter #(.CNT_W(CNT_W)) u_war_x   (.clk(clk), .clr(clr), .inc(judge & war_X), .count(cnt_war_X));
  bkm_sat_counter #(.CNT_W(CNT_W)) u_war_y   (.clk(clk), .clr(clr), .inc(judge & war_Y), .count(cnt_war_Y));
  always_ff @(posedge clk) begin
    if (clr) begin
      max_dX        <= '0;
      max_dY        <= '0;
      first_err_vld <= 1'b0;
      first_err_n   <= '0;
      first_err_idx <= '0;
    end else if (judge) begin
      if (abs_x > max_dX) max_dX <= abs_x;
      if (abs_y > max_dY) max_dY <= abs_y;
      if (err && !first_err_vld) begin
        first_err_vld <= 1'b1;
        first_err_n   <= n_d;
        first_err_idx <= cnt_samples;
      end
    end
  end
  always_ff @(posedge clk) st <= clr ? SB_IDLE : st_nx;
  always_comb st_nx = !judge ? st : err ? SB_FAIL : (st == SB_IDLE) ? SB_RUN : st;
endmodule
